wb_target_router: RTL and testbench
===================================

# wb_target_router

Registered Wishbone request router and response arbiter that sits between the Caravel management Wishbone slave port and the three user-area targets: UART, DMA configuration, and DRAM/user-project memory. It decodes each master cycle to exactly one target and drives only that target's strobe. It returns that target's data and ack on a single registered path. It terminates unmapped or hung cycles with an error word and keeps error counters. It replaces ad-hoc OR/priority muxing of `wbs_ack_o`/`wbs_dat_o` in the wrapper.

## Interface
- `UART_PREFIX`, default 16'h3000: `wbs_adr_i[31:16]` value selecting target 0 (UART).
- `DMA_PREFIX`, default 16'h3001: prefix selecting target 1 (DMA config).
- `MEM_PREFIX`, default 16'h3800: prefix selecting target 2 (DRAM/user memory).
- `TIMEOUT`, default 255: maximum cycles a target strobe stays high without ack. Range 2..255.
- `ERR_WORD`, default 32'hDEAD_BEEF: read data returned on error termination.

Ports:
- `wb_clk_i` input 1: the only clock.
- `wb_rst_i` input 1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` input 1 each: master request.
- `wbs_sel_i` input 4, `wbs_adr_i` input 32, `wbs_dat_i` input 32: master request.
- `wbs_ack_o` output 1, `wbs_dat_o` output 32: master response.
- `t_cyc_o`, `t_stb_o` output 3 each: per-target cycle/strobe; bit n drives target n.
- `t_we_o` output 1, `t_sel_o` output 4, `t_adr_o` output 32, `t_dat_o` output 32: shared request fields, latched at decode.
- `t_ack_i` input 3: per-target ack.
- `t_dat_i` input 96: packed read data, target n at bits [32n+31:32n].
- `err_count` output 8: saturating count of error terminations.
- `err_adr` output 32: address of the most recent error termination.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**, when `wbs_cyc_i & wbs_stb_i`:
  - Decode `wbs_adr_i[31:16]` against the three prefixes.
  - Latch we/sel/adr/dat into the `t_*` fields.
  - On a hit: record the target index `sel_q` and set `t_cyc_o[sel_q]`/`t_stb_o[sel_q]`. Go to WAIT and clear the timeout counter.
  - On a miss: go to RESP with `ERR_WORD`, increment `err_count`, latch `err_adr`.
- **WAIT**:
  - Only `t_ack_i[sel_q]` is honoured. Acks on the other bits are ignored and change no state.
  - On ack: capture `t_dat_i[sel_q]` into `wbs_dat_o`, drop the target cyc/stb, go to RESP.
  - If ack and timeout occur on the same edge, the ack wins.
  - Timeout: the counter increments each WAIT cycle without ack. At count == `TIMEOUT`-1 with no ack: drop the target, go to RESP with `ERR_WORD`, apply the error update.
  - Abort: if `wbs_cyc_i` goes low in WAIT, drop the target and go to IDLE. No master ack is issued and no error is counted.
- **RESP**: `wbs_ack_o`=1 for exactly this one cycle, then go to IDLE. Master request inputs are ignored in RESP.
- At most one target's `t_stb_o` bit is ever high (one-hot or zero).
- `err_count` saturates at 255. Writes that terminate with an error also count.
- `wbs_dat_o` holds its last value outside RESP. It is only meaningful while ack=1.

## Timing
- Reset, applied asynchronously: state=IDLE, `t_cyc_o`=`t_stb_o`=0, `t_we_o`=0, `t_sel_o`=0, `t_adr_o`=0, `t_dat_o`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `err_count`=0, `err_adr`=0.
- Reset mid-WAIT drops the target strobe immediately. No ack follows release.
- All outputs are registered.
- Request latency: master stb sampled at edge E0 → `t_stb_o` high from E0.
- Response latency: target ack sampled at edge Ek → `wbs_ack_o` high from Ek to Ek+1. The router is back in IDLE at Ek+1.
- Best-case round trip: target acks in its first strobe cycle → master ack in the cycle after E1 → 3 cycles from stb to ack.
- Unmapped access: ack is high in the cycle after E0.
- Timeout: target stb is high for exactly `TIMEOUT` cycles, then the master is acked in the next cycle.
- Back-to-back: a new request is accepted in IDLE on the first edge after RESP.

## Test plan
- UART read: adr 0x3000_0008, target 0 acks 2 cycles after stb with 0x0000_00A5. Expect: only `t_stb_o`=3'b001 high; `wbs_ack_o` for 1 cycle with dat 0x0000_00A5; `err_count`=0.
- Memory write: adr 0x3800_0010, dat 0x1234_5678, sel 4'hF. Expect: `t_stb_o`=3'b100, `t_we_o`=1, `t_dat_o`=0x1234_5678, `t_adr_o`=0x3800_0010; single master ack.
- Unmapped read: adr 0x2000_0000. Expect: no `t_stb_o` bit high; ack 1 cycle after stb with 0xDEAD_BEEF; `err_count`=1; `err_adr`=0x2000_0000.
- Timeout: target 1 never acks, `TIMEOUT`=255. Expect: `t_stb_o[1]` high for exactly 255 cycles, then master ack with 0xDEAD_BEEF; `err_count` increments. After 300 timeouts `err_count`=255.
- Stray ack and abort:
  - During WAIT on target 2, pulse `t_ack_i[0]`. Expect: no master ack.
  - Then drop `wbs_cyc_i`. Expect: `t_stb_o`=0 next cycle, no ack, counters unchanged.
- Reset mid-WAIT: assert `wb_rst_i`=0 asynchronously. Expect: all outputs 0 without waiting for a clock edge. After release, a normal UART read completes.

Source files
------------

// File: rtl/wb_target_router_if.sv
// Bus bundle between the management Wishbone slave port and the three user-area targets.
// Handshake: a master request is valid while cyc&stb are high and is accepted when the router
// samples it in IDLE; a target completes by raising its t_ack_i bit while its t_stb_o bit is high;
// the router answers the master with a single-cycle wbs_ack_o, with wbs_dat_o valid only during it.
interface wb_target_router_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [2:0]  t_cyc_o;
  logic [2:0]  t_stb_o;
  logic        t_we_o;
  logic [3:0]  t_sel_o;
  logic [31:0] t_adr_o;
  logic [31:0] t_dat_o;
  logic [2:0]  t_ack_i;
  logic [95:0] t_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output t_cyc_o, t_stb_o, t_we_o, t_sel_o, t_adr_o, t_dat_o,
    input  t_ack_i, t_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  t_cyc_o, t_stb_o, t_we_o, t_sel_o, t_adr_o, t_dat_o,
    output t_ack_i, t_dat_i
  );
endinterface

// File: rtl/wb_target_router.sv
// Registered Wishbone router: decodes one master cycle to one of three targets, returns its
// data/ack on a single registered path, and terminates unmapped or hung cycles with an error word.
module wb_target_router #(
  parameter logic [15:0] UART_PREFIX = 16'h3000,
  parameter logic [15:0] DMA_PREFIX  = 16'h3001,
  parameter logic [15:0] MEM_PREFIX  = 16'h3800,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_WORD    = 32'hDEAD_BEEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_target_router_if.slave     bus,
  output logic [7:0]            err_count,
  output logic [31:0]           err_adr,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [2:0]  tgt_q, tgt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [31:0] err_adr_q, err_adr_d;

  logic        dec_hit;
  logic [1:0]  dec_idx;
  logic        tgt_ack;
  logic [31:0] tgt_rdat;

  always_comb begin
    dec_hit = 1'b1;
    dec_idx = 2'd0;
    if (bus.wbs_adr_i[31:16] == UART_PREFIX)      dec_idx = 2'd0;
    else if (bus.wbs_adr_i[31:16] == DMA_PREFIX)  dec_idx = 2'd1;
    else if (bus.wbs_adr_i[31:16] == MEM_PREFIX)  dec_idx = 2'd2;
    else                                          dec_hit = 1'b0;
  end

  // Only the selected target's ack and data are ever looked at.
  always_comb begin
    tgt_ack  = 1'b0;
    tgt_rdat = bus.t_dat_i[31:0];
    case (sel_q)
      2'd0: begin tgt_ack = bus.t_ack_i[0]; tgt_rdat = bus.t_dat_i[31:0];  end
      2'd1: begin tgt_ack = bus.t_ack_i[1]; tgt_rdat = bus.t_dat_i[63:32]; end
      2'd2: begin tgt_ack = bus.t_ack_i[2]; tgt_rdat = bus.t_dat_i[95:64]; end
      default: begin tgt_ack = 1'b0; tgt_rdat = bus.t_dat_i[31:0]; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tmo_d     = tmo_q;
    tgt_d     = tgt_q;
    we_d      = we_q;
    be_d      = be_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;
    err_cnt_d = err_cnt_q;
    err_adr_d = err_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          we_d   = bus.wbs_we_i;
          be_d   = bus.wbs_sel_i;
          adr_d  = bus.wbs_adr_i;
          wdat_d = bus.wbs_dat_i;
          if (dec_hit) begin
            sel_d   = dec_idx;
            tgt_d   = 3'b001 << dec_idx;
            tmo_d   = 8'd0;
            state_d = ST_WAIT;
          end else begin
            ack_d     = 1'b1;
            rdat_d    = ERR_WORD;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            err_adr_d = bus.wbs_adr_i;
            state_d   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        // Master abort beats ack, and ack beats timeout on the same edge.
        if (!bus.wbs_cyc_i) begin
          tgt_d   = 3'b000;
          state_d = ST_IDLE;
        end else if (tgt_ack) begin
          tgt_d   = 3'b000;
          ack_d   = 1'b1;
          rdat_d  = tgt_rdat;
          state_d = ST_RESP;
        end else if (tmo_q == TMO_LAST) begin
          tgt_d     = 3'b000;
          ack_d     = 1'b1;
          rdat_d    = ERR_WORD;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          err_adr_d = adr_q;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        tgt_d   = 3'b000;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      tmo_q     <= 8'd0;
      tgt_q     <= 3'b000;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      adr_q     <= 32'h0;
      wdat_q    <= 32'h0;
      ack_q     <= 1'b0;
      rdat_q    <= 32'h0;
      err_cnt_q <= 8'h0;
      err_adr_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      tgt_q     <= tgt_d;
      we_q      <= we_d;
      be_q      <= be_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      err_cnt_q <= err_cnt_d;
      err_adr_q <= err_adr_d;
    end
  end

  assign bus.t_cyc_o   = tgt_q;
  assign bus.t_stb_o   = tgt_q;
  assign bus.t_we_o    = we_q;
  assign bus.t_sel_o   = be_q;
  assign bus.t_adr_o   = adr_q;
  assign bus.t_dat_o   = wdat_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign err_count     = err_cnt_q;
  assign err_adr       = err_adr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_wb_target_router.sv
// Bench for wb_target_router: transaction-level model of the router's outcomes,
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_wb_target_router;
  localparam int TMO = 255;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0]  err_count;
  logic [31:0] err_adr;
  logic [1:0]  dbg_state;

  wb_target_router_if bus ();

  wb_target_router #(.TIMEOUT(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .bus         (bus),
    .err_count   (err_count),
    .err_adr     (err_adr),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [2:0]  exp_tstb = '0;
  logic        exp_ack  = 1'b0;
  logic        exp_we   = 1'b0;
  logic [3:0]  exp_sel  = '0;
  logic [31:0] exp_adr  = '0;
  logic [31:0] exp_tdat = '0;
  logic [7:0]  exp_ec   = '0;
  logic [31:0] exp_ea   = '0;
  logic [31:0] exp_q[$];

  // observations used by the literal checks
  int          ack_cnt = 0;
  int          stb_cnt[3] = '{0, 0, 0};
  logic [31:0] last_ack_dat = '0;
  logic [2:0]  snap_stb = '0;
  logic        snap_we = 1'b0;
  logic [31:0] snap_adr = '0;
  logic [31:0] snap_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int target_of(input logic [31:0] a);
    case (a[31:16])
      16'h3000: return 0;
      16'h3001: return 1;
      16'h3800: return 2;
      default:  return 3;
    endcase
  endfunction

  task automatic err_event(input logic [31:0] a);
    exp_ec = (exp_ec == 8'd255) ? 8'd255 : exp_ec + 8'd1;
    exp_ea = a;
  endtask

  task automatic model_reset();
    exp_tstb = '0; exp_ack = 1'b0; exp_we = 1'b0; exp_sel = '0;
    exp_adr = '0; exp_tdat = '0; exp_ec = '0; exp_ea = '0;
    exp_q.delete();
  endtask

  // compare process
  always @(negedge clk) begin
    chk("t_stb", {29'd0, bus.t_stb_o}, {29'd0, exp_tstb});
    chk("t_cyc", {29'd0, bus.t_cyc_o}, {29'd0, exp_tstb});
    chk("ack", {31'd0, bus.wbs_ack_o}, {31'd0, exp_ack});
    chk("t_we", {31'd0, bus.t_we_o}, {31'd0, exp_we});
    chk("t_sel", {28'd0, bus.t_sel_o}, {28'd0, exp_sel});
    chk("t_adr", bus.t_adr_o, exp_adr);
    chk("t_dat", bus.t_dat_o, exp_tdat);
    chk("err_count", {24'd0, err_count}, {24'd0, exp_ec});
    chk("err_adr", err_adr, exp_ea);
    if (bus.wbs_ack_o === 1'b1) begin
      ack_cnt++;
      last_ack_dat = bus.wbs_dat_o;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        chk("rdata", bus.wbs_dat_o, exp_q.pop_front());
      end
    end
    for (int n = 0; n < 3; n++) if (bus.t_stb_o[n] === 1'b1) stb_cnt[n]++;
    if (bus.t_stb_o !== 3'b000) begin
      snap_stb = bus.t_stb_o; snap_we = bus.t_we_o;
      snap_adr = bus.t_adr_o; snap_dat = bus.t_dat_o;
    end
  end

  task automatic clear_obs();
    ack_cnt = 0;
    for (int n = 0; n < 3; n++) stb_cnt[n] = 0;
  endtask

  // One master cycle. ack_dly: strobe cycles before the target acks; abort_at: strobe
  // cycle in which the master drops cyc. Values >= TMO mean "never".
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_dly, input int abort_at,
                        input logic [31:0] rd);
    int tgt;
    int k;
    bit acked, aborted, timed_out;
    tgt = target_of(adr);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
    @(posedge clk); #1;
    exp_we = we; exp_sel = sel; exp_adr = adr; exp_tdat = dat;
    if (tgt == 3) begin
      exp_ack = 1'b1;
      exp_q.push_back(ERRW);
      err_event(adr);
    end else begin
      exp_tstb = 3'b001 << tgt;
      k = 0; acked = 0; aborted = 0; timed_out = 0;
      while (!acked && !aborted) begin
        bus.t_ack_i = 3'($urandom_range(0, 7)) & ~(3'b001 << tgt);
        bus.t_dat_i = {$urandom, $urandom, $urandom};
        if (k == abort_at) begin
          bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; aborted = 1;
        end else if (k == ack_dly) begin
          bus.t_ack_i[tgt] = 1'b1;
          bus.t_dat_i[tgt*32 +: 32] = rd;
          acked = 1;
        end else if (k == TMO - 1) begin
          acked = 1; timed_out = 1;
        end
        @(posedge clk); #1;
        k++;
      end
      bus.t_ack_i = 3'b000;
      exp_tstb = 3'b000;
      if (acked) begin
        exp_ack = 1'b1;
        if (timed_out) begin
          exp_q.push_back(ERRW);
          err_event(exp_adr);
        end else begin
          exp_q.push_back(rd);
        end
      end
    end
    if (exp_ack) begin
      // a new request presented during the response cycle must be ignored
      bus.wbs_adr_i = $urandom;
      bus.wbs_we_i  = 1'($urandom_range(0, 1));
      bus.wbs_cyc_i = 1'($urandom_range(0, 1));
      bus.wbs_stb_i = bus.wbs_cyc_i;
      @(posedge clk); #1;
      exp_ack = 1'b0;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.t_ack_i = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    bus.t_ack_i = 3'b000;
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] a;
    int pick, dly, ab;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    bus.t_ack_i = '0; bus.t_dat_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);
    chk("reset_err_count", {24'd0, err_count}, 32'd0);
    chk("reset_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("reset_dat", bus.wbs_dat_o, 32'd0);

    // UART read
    clear_obs();
    do_txn(32'h3000_0008, 1'b0, 32'h0, 4'hF, 2, TMO, 32'h0000_00A5);
    idle_cycles(1);
    chk("uart_dat", last_ack_dat, 32'h0000_00A5);
    chk("uart_acks", ack_cnt, 1);
    chk("uart_stb_cycles", stb_cnt[0], 3);
    chk("uart_other_stb", stb_cnt[1] + stb_cnt[2], 0);
    chk("uart_err", {24'd0, err_count}, 32'd0);

    // Memory write
    clear_obs();
    do_txn(32'h3800_0010, 1'b1, 32'h1234_5678, 4'hF, 1, TMO, 32'h0);
    chk("memw_stb", {29'd0, snap_stb}, 32'd4);
    chk("memw_we", {31'd0, snap_we}, 32'd1);
    chk("memw_dat", snap_dat, 32'h1234_5678);
    chk("memw_adr", snap_adr, 32'h3800_0010);
    chk("memw_acks", ack_cnt, 1);

    // Unmapped read
    clear_obs();
    do_txn(32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, TMO, 32'h0);
    chk("unmap_dat", last_ack_dat, 32'hDEAD_BEEF);
    chk("unmap_err_count", {24'd0, err_count}, 32'd1);
    chk("unmap_err_adr", err_adr, 32'h2000_0000);
    chk("unmap_stb", stb_cnt[0] + stb_cnt[1] + stb_cnt[2], 0);

    // Timeout on DMA
    clear_obs();
    do_txn(32'h3001_0004, 1'b0, 32'h0, 4'hF, TMO, TMO, 32'h0);
    chk("tmo_stb_cycles", stb_cnt[1], 255);
    chk("tmo_dat", last_ack_dat, 32'hDEAD_BEEF);
    chk("tmo_err_count", {24'd0, err_count}, 32'd2);
    chk("tmo_err_adr", err_adr, 32'h3001_0004);

    // Stray acks then abort on memory target
    clear_obs();
    do_txn(32'h3800_0020, 1'b0, 32'h0, 4'hF, TMO, 4, 32'h0);
    idle_cycles(1);
    chk("abort_acks", ack_cnt, 0);
    chk("abort_stb_cycles", stb_cnt[2], 5);
    chk("abort_err_count", {24'd0, err_count}, 32'd2);

    // Reset mid-WAIT
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_sel_i = 4'h3; bus.wbs_adr_i = 32'h3800_0040; bus.wbs_dat_i = 32'hCAFE_0001;
    @(posedge clk); #1;
    exp_tstb = 3'b100; exp_we = 1'b1; exp_sel = 4'h3;
    exp_adr = 32'h3800_0040; exp_tdat = 32'hCAFE_0001;
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_stb", {29'd0, bus.t_stb_o}, 32'd0);
    chk("rst_we", {31'd0, bus.t_we_o}, 32'd0);
    chk("rst_adr", bus.t_adr_o, 32'd0);
    chk("rst_tdat", bus.t_dat_o, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_err_adr", err_adr, 32'd0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    idle_cycles(2);
    chk("post_rst_acks", ack_cnt, 0);
    do_txn(32'h3000_0008, 1'b0, 32'h0, 4'hF, 0, TMO, 32'h0000_005A);
    chk("post_rst_dat", last_ack_dat, 32'h0000_005A);
    chk("post_rst_acks2", ack_cnt, 1);

    // Random traffic
    for (int t = 0; t < 250; t++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0: a = {16'h3000, 16'($urandom)};
        1: a = {16'h3001, 16'($urandom)};
        2: a = {16'h3800, 16'($urandom)};
        default: a = $urandom;
      endcase
      dly = ($urandom_range(0, 99) < 2) ? TMO : $urandom_range(0, 6);
      ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : TMO;
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), dly, ab, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    // Saturation of the error counter
    for (int t = 0; t < 300; t++) begin
      do_txn({16'h1000, 16'($urandom)}, 1'($urandom_range(0, 1)), $urandom, 4'hF, 0, TMO, 32'h0);
    end
    idle_cycles(1);
    chk("sat_err_count", {24'd0, err_count}, 32'd255);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
